// File: rtl/oam_dma_ctrl_pkg.sv
// Shared constants, state encodings and helpers for the OAM DMA controller.
package oam_dma_ctrl_pkg;
    localparam logic [15:0] DEF_DMA_REG_ADDR = 16'hFF46;
    localparam int          DEF_DMA_LEN      = 160;
    localparam logic [15:0] DEF_OAM_BASE     = 16'hFE00;
    localparam logic [15:0] DEF_HRAM_BASE    = 16'hFF80;
    localparam int          IDX_W            = 8;

    localparam logic SEL_CPU = 1'b0;
    localparam logic SEL_DMA = 1'b1;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_START = 3'd1;
    localparam state_t ST_RD    = 3'd2;
    localparam state_t ST_WR    = 3'd3;
    localparam state_t ST_WAIT  = 3'd4;

    // Pages E0-FF alias echo RAM; fold them back onto C0-DF.
    function automatic logic [7:0] fold_page(input logic [7:0] p);
        logic [7:0] f;
        f = p;
        if (p >= 8'hE0) f[5] = 1'b0;
        return f;
    endfunction
endpackage

// File: rtl/dma_byte_counter.sv
// Transfer byte index: cleared on trigger, advanced once per M-cycle, flags the final byte.
module dma_byte_counter
    import oam_dma_ctrl_pkg::*;
#(
    parameter int LEN = DEF_DMA_LEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             step,
    input  logic             m_tick,
    output logic [IDX_W-1:0] idx,
    output logic             last
);
    assign last = (idx == IDX_W'(LEN - 1));

    // Saturates on the final byte so the index never points past the OAM window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          idx <= '0;
        else if (clear)                   idx <= '0;
        else if (step && m_tick && !last) idx <= idx + 1'b1;
    end
endmodule

// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller and memory-bus arbiter: copies DMA_LEN bytes from {page,00} into OAM.
// Define OAM_DMA_RESTART_EN to let a register write abandon and restart a running transfer.
module oam_dma_ctrl
    import oam_dma_ctrl_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR = DEF_DMA_REG_ADDR,
    parameter int          DMA_LEN      = DEF_DMA_LEN,
    parameter logic [15:0] OAM_BASE     = DEF_OAM_BASE,
    parameter logic [15:0] HRAM_BASE    = DEF_HRAM_BASE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m_tick,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_wr_en,
    input  logic [7:0]  cpu_wr_data,
    output logic [7:0]  reg_rd_data,
    output logic        dma_active,
    output logic        mem_ctrl_sel,
    output logic [15:0] dma_addr,
    output logic        dma_rd,
    output logic        dma_wr,
    output logic [7:0]  dma_data_out,
    input  logic [7:0]  dma_data_in,
    output logic        cpu_block,
    output logic        dma_done
);
    state_t           state, state_nxt;
    logic [7:0]       page;
    logic [7:0]       data_q;
    logic             hold_sel;
    logic             sel_dma;
    logic             trig;
    logic             accept;
    logic [IDX_W-1:0] idx;
    logic             last;

    assign trig = cpu_wr_en && (cpu_addr == DMA_REG_ADDR);
`ifdef OAM_DMA_RESTART_EN
    assign accept = trig;
`else
    assign accept = trig && (state == ST_IDLE);
`endif

    dma_byte_counter #(.LEN(DMA_LEN)) u_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept),
        .step   (state == ST_WAIT),
        .m_tick (m_tick),
        .idx    (idx),
        .last   (last)
    );

    // A trigger in the same clk as m_tick lands in START, so that tick is never counted.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  state_nxt = ST_IDLE;
            ST_START: if (m_tick) state_nxt = ST_RD;
            ST_RD:    state_nxt = ST_WR;
            ST_WR:    state_nxt = last ? ST_IDLE : ST_WAIT;
            ST_WAIT:  if (m_tick) state_nxt = ST_RD;
            default:  state_nxt = ST_IDLE;
        endcase
        if (accept) state_nxt = ST_START;
    end

    always_comb begin
        sel_dma = 1'b0;
        case (state)
            ST_RD, ST_WR, ST_WAIT: sel_dma = 1'b1;
            ST_START:              sel_dma = hold_sel;
            default:               sel_dma = 1'b0;
        endcase
    end

    // hold_sel keeps the bus on the DMA side across a restart's START phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            page     <= 8'h00;
            data_q   <= 8'h00;
            hold_sel <= 1'b0;
            dma_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            dma_done <= (state == ST_WR) && last && !accept;
            if (accept) begin
                page     <= fold_page(cpu_wr_data);
                hold_sel <= sel_dma;
            end
            if (state == ST_RD) data_q <= dma_data_in;
        end
    end

    assign dma_rd       = (state == ST_RD);
    assign dma_wr       = (state == ST_WR);
    assign dma_active   = (state != ST_IDLE);
    assign mem_ctrl_sel = sel_dma ? SEL_DMA : SEL_CPU;
    assign reg_rd_data  = page;
    assign cpu_block    = dma_active && (cpu_addr < HRAM_BASE);
    assign dma_addr     = dma_rd ? {page, idx} :
                          dma_wr ? OAM_BASE + {8'h00, idx} : 16'h0000;
    assign dma_data_out = dma_wr ? data_q : 8'h00;
endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Bench for oam_dma_ctrl: table vectors, directed corner sequences and random traffic
// checked every clk against a transaction-level model of the copy schedule.
module tb_oam_dma_ctrl;
`ifdef OAM_DMA_RESTART_EN
    localparam bit RESTART = 1'b1;
`else
    localparam bit RESTART = 1'b0;
`endif
    localparam int NEVER = 32'h7fff_ffff;
    localparam int LEN   = 160;

    typedef struct packed {
        logic [7:0]  reg_v;
        logic        active;
        logic        sel;
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  dout;
        logic        block;
        logic        done;
    } obs_t;

    typedef struct {
        logic [15:0] addr;
        logic        wr;
        logic [7:0]  data;
        logic [7:0]  exp_reg;
        logic        exp_active;
        logic        exp_block;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m_tick = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic        cpu_wr_en = 1'b0;
    logic [7:0]  cpu_wr_data = 8'h00;
    logic [7:0]  reg_rd_data;
    logic        dma_active;
    logic        mem_ctrl_sel;
    logic [15:0] dma_addr;
    logic        dma_rd;
    logic        dma_wr;
    logic [7:0]  dma_data_out;
    logic [7:0]  dma_data_in;
    logic        cpu_block;
    logic        dma_done;

    logic [7:0] mem [0:65535];
    assign dma_data_in = mem[dma_addr];

    always #5 clk = ~clk;

    oam_dma_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .m_tick       (m_tick),
        .cpu_addr     (cpu_addr),
        .cpu_wr_en    (cpu_wr_en),
        .cpu_wr_data  (cpu_wr_data),
        .reg_rd_data  (reg_rd_data),
        .dma_active   (dma_active),
        .mem_ctrl_sel (mem_ctrl_sel),
        .dma_addr     (dma_addr),
        .dma_rd       (dma_rd),
        .dma_wr       (dma_wr),
        .dma_data_out (dma_data_out),
        .dma_data_in  (dma_data_in),
        .cpu_block    (cpu_block),
        .dma_done     (dma_done)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Model: each run is described by the cycles at which it is active, when it owns
    // the bus, and the per-cycle read/write events scheduled from counted M-cycle ticks.
    logic [7:0]  m_page;
    int          act_from, act_to, sel_from, done_cyc, k;
    logic [15:0] rd_at [int];
    logic [15:0] wr_at [int];
    logic [7:0]  wd_at [int];

    int          tick_cnt = 0;
    bit          tick_en = 1'b0;
    bit          rand_period = 1'b0;
    int          period = 4;

    int          wr_count, done_count, sel_drops, mark_rd_cyc;
    logic [15:0] first_rd, first_wr, last_wr, mark_rd;
    bit          seen_rd, seen_wr, mark, mark_seen;
    logic [7:0]  oam [0:255];

    function automatic bit m_active(input int c);
        return (c >= act_from) && (c < act_to);
    endfunction

    function automatic logic [7:0] fold(input logic [7:0] p);
        return (p >= 8'hE0) ? p - 8'h20 : p;
    endfunction

    task automatic model_reset();
        m_page = 8'h00; act_from = NEVER; act_to = NEVER; sel_from = NEVER;
        done_cyc = NEVER; k = 0;
        rd_at.delete(); wr_at.delete(); wd_at.delete();
    endtask

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_outputs();
        obs_t e, a;
        bit act;
        act = m_active(cyc);
        e = '0;
        e.reg_v  = m_page;
        e.active = act;
        e.sel    = act && (cyc >= sel_from);
        e.rd     = rd_at.exists(cyc);
        e.wr     = wr_at.exists(cyc);
        if (e.rd) e.addr = rd_at[cyc];
        else if (e.wr) e.addr = wr_at[cyc];
        if (e.wr) e.dout = wd_at[cyc];
        e.block  = act && (cpu_addr < 16'hFF80);
        e.done   = (cyc == done_cyc);
        a = {reg_rd_data, dma_active, mem_ctrl_sel, dma_rd, dma_wr, dma_addr,
             dma_data_out, cpu_block, dma_done};
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL cycle %0d outputs: got reg=%h act=%b sel=%b rd=%b wr=%b addr=%h dout=%h blk=%b done=%b, expected reg=%h act=%b sel=%b rd=%b wr=%b addr=%h dout=%h blk=%b done=%b",
                     cyc, a.reg_v, a.active, a.sel, a.rd, a.wr, a.addr, a.dout, a.block, a.done,
                     e.reg_v, e.active, e.sel, e.rd, e.wr, e.addr, e.dout, e.block, e.done);
        end
    endtask

    task automatic model_update();
        bit act, trig, acc;
        logic [15:0] src;
        if (rst) return;
        act  = m_active(cyc);
        trig = cpu_wr_en && (cpu_addr == 16'hFF46);
        acc  = trig && (!act || RESTART);
        if (acc) begin
            if (done_cyc > cyc) done_cyc = NEVER;
            sel_from = (act && cyc >= sel_from) ? cyc + 1 : NEVER;
            m_page   = fold(cpu_wr_data);
            act_from = cyc + 1;
            act_to   = NEVER;
            k        = 0;
            for (int d = 1; d <= 2; d++) begin
                rd_at.delete(cyc + d); wr_at.delete(cyc + d); wd_at.delete(cyc + d);
            end
        end else if (m_tick && act && k < LEN) begin
            src = {m_page, 8'(k)};
            rd_at[cyc + 1] = src;
            wr_at[cyc + 2] = 16'hFE00 + 16'(k);
            wd_at[cyc + 2] = mem[src];
            if (sel_from > cyc + 1) sel_from = cyc + 1;
            k++;
            if (k == LEN) begin
                act_to   = cyc + 3;
                done_cyc = cyc + 3;
            end
        end
    endtask

    task automatic step();
        if (tick_en) begin
            m_tick = (tick_cnt == 0);
            if (tick_cnt == 0) tick_cnt = rand_period ? int'($urandom_range(5, 2)) : period - 1;
            else tick_cnt = tick_cnt - 1;
        end else begin
            m_tick = 1'b0;
        end
        if (rst) model_reset();
        #1;
        check_outputs();
        if (dma_wr) begin
            oam[dma_addr[7:0]] = dma_data_out;
            wr_count++;
            if (!seen_wr) first_wr = dma_addr;
            seen_wr = 1'b1;
            last_wr = dma_addr;
        end
        if (dma_rd) begin
            if (!seen_rd) first_rd = dma_addr;
            seen_rd = 1'b1;
            if (mark && !mark_seen) begin
                mark_rd = dma_addr; mark_rd_cyc = cyc; mark_seen = 1'b1;
            end
        end
        if (mark && !mark_seen && !mem_ctrl_sel) sel_drops++;
        if (dma_done) done_count++;
        model_update();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic reset_tracking();
        wr_count = 0; done_count = 0; sel_drops = 0;
        seen_rd = 1'b0; seen_wr = 1'b0; mark = 1'b0; mark_seen = 1'b0;
        first_rd = 16'h0; first_wr = 16'h0; last_wr = 16'h0; mark_rd = 16'h0; mark_rd_cyc = 0;
    endtask

    task automatic write_reg(input logic [15:0] addr, input logic [7:0] data);
        cpu_addr = addr; cpu_wr_en = 1'b1; cpu_wr_data = data;
        step();
        cpu_wr_en = 1'b0;
    endtask

    task automatic run_until_idle(input string name);
        int n = 0;
        while (!(act_to != NEVER && cyc > act_to) && n < 3000) begin
            step();
            n++;
        end
        if (n >= 3000) begin
            vectors++; miscompares++;
            $display("FAIL %s: transfer not finished within 3000 cycles", name);
        end
    endtask

    task automatic run_until_writes(input string name, input int target);
        int n = 0;
        while (wr_count < target && n < 3000) begin
            step();
            n++;
        end
        if (n >= 3000) begin
            vectors++; miscompares++;
            $display("FAIL %s: only %0d writes seen, wanted %0d", name, wr_count, target);
        end
    endtask

    initial begin
        vec_t tbl [10];
        int   trig_cyc;
        int   n;

        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'hC200 + i] = 8'(i);

        tbl[0] = '{16'hFF45, 1'b1, 8'h12, 8'h00, 1'b0, 1'b0};
        tbl[1] = '{16'hFF46, 1'b0, 8'hC1, 8'h00, 1'b0, 1'b0};
        tbl[2] = '{16'hC000, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[3] = '{16'hFF46, 1'b1, 8'hE2, 8'hC2, 1'b1, 1'b1};
        tbl[4] = '{16'hC000, 1'b0, 8'h00, 8'hC2, 1'b1, 1'b1};
        tbl[5] = '{16'hFF90, 1'b0, 8'h00, 8'hC2, 1'b1, 1'b0};
        tbl[6] = '{16'hFF80, 1'b0, 8'h00, 8'hC2, 1'b1, 1'b0};
        tbl[7] = '{16'hFF7F, 1'b0, 8'h00, 8'hC2, 1'b1, 1'b1};
        tbl[8] = '{16'hFF47, 1'b1, 8'h55, 8'hC2, 1'b1, 1'b1};
        tbl[9] = '{16'hFFFF, 1'b0, 8'h00, 8'hC2, 1'b1, 1'b0};

        model_reset();
        reset_tracking();
        #1 rst = 1'b1;
        step();
        cmp("reset_outputs", {8'h0, reg_rd_data, dma_active, mem_ctrl_sel, dma_rd, dma_wr,
                              dma_addr[7:0], dma_data_out, cpu_block, dma_done, 2'b00}, 32'h0);
        step();
        rst = 1'b0;
        step();

        // Register decode and cpu_block boundaries, held in START with no ticks.
        foreach (tbl[i]) begin
            cpu_addr = tbl[i].addr; cpu_wr_en = tbl[i].wr; cpu_wr_data = tbl[i].data;
            step();
            cpu_wr_en = 1'b0;
            #1;
            cmp($sformatf("tbl%0d_reg", i), 32'(reg_rd_data), 32'(tbl[i].exp_reg));
            cmp($sformatf("tbl%0d_active", i), 32'(dma_active), 32'(tbl[i].exp_active));
            cmp($sformatf("tbl%0d_block", i), 32'(cpu_block), 32'(tbl[i].exp_block));
            cmp($sformatf("tbl%0d_sel", i), 32'(mem_ctrl_sel), 32'h0);
        end

        // Echo page E2 copies C200.. into OAM.
        tick_en = 1'b1; tick_cnt = 0; period = 4;
        run_until_idle("e2_copy");
        cmp("e2_first_rd", 32'(first_rd), 32'hC200);
        cmp("e2_last_wr", 32'(last_wr), 32'hFE9F);
        cmp("e2_writes", wr_count, 160);
        cmp("e2_reg", 32'(reg_rd_data), 32'hC2);
        for (int i = 0; i < LEN; i++) cmp($sformatf("e2_oam%0d", i), 32'(oam[i]), i);

        // Page C1 full transfer with mid-run cpu_block probes.
        reset_tracking();
        write_reg(16'hFF46, 8'hC1);
        run_until_writes("c1_mid", 10);
        cpu_addr = 16'hC000; #1; cmp("c1_block_c000", 32'(cpu_block), 32'h1);
        cpu_addr = 16'hFF90; #1; cmp("c1_block_ff90", 32'(cpu_block), 32'h0);
        run_until_idle("c1_copy");
        cmp("c1_first_rd", 32'(first_rd), 32'hC100);
        cmp("c1_first_wr", 32'(first_wr), 32'hFE00);
        cmp("c1_last_wr", 32'(last_wr), 32'hFE9F);
        cmp("c1_writes", wr_count, 160);
        cmp("c1_done_pulses", done_count, 1);
        cpu_addr = 16'hC000; #1;
        cmp("c1_block_after", 32'(cpu_block), 32'h0);
        cmp("c1_sel_after", 32'(mem_ctrl_sel), 32'h0);
        for (int i = 0; i < LEN; i += 17) cmp($sformatf("c1_oam%0d", i), 32'(oam[i]), 32'(mem[16'hC100 + i]));

        // Reset in WAIT after byte 50.
        reset_tracking();
        write_reg(16'hFF46, 8'hC3);
        run_until_writes("rst_mid", 51);
        rst = 1'b1;
        step();
        cmp("rst_outputs", {8'h0, reg_rd_data, dma_active, mem_ctrl_sel, dma_rd, dma_wr,
                            dma_addr[7:0] | dma_addr[15:8], dma_data_out, cpu_block, dma_done, 2'b00}, 32'h0);
        rst = 1'b0;
        repeat (20) step();
        cmp("rst_writes_after", wr_count, 51);
        cmp("rst_reg", 32'(reg_rd_data), 32'h0);
        cmp("rst_active", 32'(dma_active), 32'h0);

        // Second trigger at byte 80.
        reset_tracking();
        write_reg(16'hFF46, 8'hC1);
        run_until_writes("retrig_mid", 81);
        write_reg(16'hFF46, 8'hD0);
        mark = 1'b1;
        run_until_idle("retrig");
        cmp("retrig_done_pulses", done_count, 1);
        cmp("retrig_last_wr", 32'(last_wr), 32'hFE9F);
        cmp("retrig_sel_drops", sel_drops, 0);
        if (RESTART) begin
            cmp("retrig_next_rd", 32'(mark_rd), 32'hD000);
            cmp("retrig_writes", wr_count, 81 + 160);
            cmp("retrig_reg", 32'(reg_rd_data), 32'hD0);
        end else begin
            cmp("retrig_next_rd", 32'(mark_rd), 32'hC151);
            cmp("retrig_writes", wr_count, 160);
            cmp("retrig_reg", 32'(reg_rd_data), 32'hC1);
        end

        // Trigger coincident with m_tick: that tick must not start the copy.
        reset_tracking();
        n = 0;
        while (tick_cnt != 0 && n < 10) begin
            step();
            n++;
        end
        trig_cyc = cyc;
        write_reg(16'hFF46, 8'h40);
        mark = 1'b1;
        run_until_idle("coincident");
        cmp("coinc_rd_cycle", mark_rd_cyc, trig_cyc + period + 1);
        cmp("coinc_rd_addr", 32'(mark_rd), 32'h4000);

        // Random traffic: spurious writes, triggers, varying tick spacing, rare resets.
        rand_period = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            int r;
            r = int'($urandom_range(999, 0));
            cpu_addr  = 16'($urandom);
            cpu_wr_en = 1'b0;
            if (r < 3) begin
                cpu_addr = 16'hFF46; cpu_wr_en = 1'b1; cpu_wr_data = 8'($urandom);
            end else if (r < 40) begin
                cpu_wr_en = 1'b1; cpu_wr_data = 8'($urandom);
                if (cpu_addr == 16'hFF46) cpu_addr = 16'hFF47;
            end else if (r == 999) begin
                rst = 1'b1;
            end
            step();
            rst = 1'b0;
        end
        cpu_wr_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
